// File: rtl/spi_ram_pkg.sv
// Shared command codes and FSM state encoding for the SPI-to-RAM command sequencer.
package spi_ram_pkg;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WRITE    = 3'd1,
      RD_ISSUE = 3'd2,
      RD_WAIT  = 3'd3,
      TX_HOLD  = 3'd4
   } state_t;

endpackage

// File: rtl/spi_ram_ctrl.sv
// Command sequencer between the SPI slave word interface and a synchronous single-port RAM.
//
// state    | meaning
// IDLE     | waiting for a command word
// WRITE    | one-cycle RAM write strobe at wr_addr
// RD_ISSUE | one-cycle RAM read strobe at rd_addr
// RD_WAIT  | RD_LAT cycles for mem_rdata, captured on the last one
// TX_HOLD  | tx_valid held until tx_ack or a new command
module spi_ram_ctrl
   import spi_ram_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int RD_LAT   = 1,
   parameter int AUTO_INC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [9:0]        rx_data,
   input  logic              rx_valid,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              err_ovr,
   output logic              err_seq
);

   localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

   state_t            state;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_addr_valid;
   logic [1:0]        wait_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wr_addr       <= '0;
         rd_addr       <= '0;
         rd_addr_valid <= 1'b0;
         wait_cnt      <= '0;
         tx_data       <= '0;
         tx_valid      <= 1'b0;
         mem_en        <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         busy          <= 1'b0;
         err_ovr       <= 1'b0;
         err_seq       <= 1'b0;
      end else begin
         mem_en  <= 1'b0;
         err_ovr <= 1'b0;
         err_seq <= 1'b0;
         case (state)
            IDLE, TX_HOLD: begin
               if (state == TX_HOLD && (tx_ack || rx_valid)) begin
                  tx_valid <= 1'b0;
                  state    <= IDLE;
               end
               if (rx_valid) begin
                  case (rx_data[9:8])
                     CMD_WR_ADDR: wr_addr <= rx_data[ADDR_W-1:0];
                     CMD_WR_DATA: begin
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= wr_addr;
                        mem_wdata <= rx_data[7:0];
                        busy      <= 1'b1;
                        state     <= WRITE;
                     end
                     CMD_RD_ADDR: begin
                        rd_addr       <= rx_data[ADDR_W-1:0];
                        rd_addr_valid <= 1'b1;
                     end
                     CMD_RD_DATA: begin
                        if (rd_addr_valid) begin
                           mem_en   <= 1'b1;
                           mem_we   <= 1'b0;
                           mem_addr <= rd_addr;
                           busy     <= 1'b1;
                           state    <= RD_ISSUE;
                        end else begin
                           err_seq <= 1'b1;
                        end
                     end
                  endcase
               end
            end
            WRITE: begin
               if (AUTO_INC != 0) wr_addr <= wr_addr + ADDR_W'(1);
               err_ovr <= rx_valid;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            RD_ISSUE: begin
               if (AUTO_INC != 0) rd_addr <= rd_addr + ADDR_W'(1);
               err_ovr  <= rx_valid;
               wait_cnt <= WAIT_LOAD;
               state    <= RD_WAIT;
            end
            RD_WAIT: begin
               err_ovr <= rx_valid;
               if (wait_cnt == 2'd0) begin
                  tx_data  <= mem_rdata;
                  tx_valid <= 1'b1;
                  busy     <= 1'b0;
                  state    <= TX_HOLD;
               end else begin
                  wait_cnt <= wait_cnt - 2'd1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: three instances cover RD_LAT=2, auto-increment with wrap, and a 4-bit address.
module tb_spi_ram_ctrl;
   import spi_ram_pkg::*;

   logic       clk;
   logic       rst_n;
   logic [9:0] rx_data;
   logic [2:0] rx_valid;
   logic [2:0] tx_ack;
   int         n_checks;
   int         n_fail;

   logic [7:0] a_tx_data, a_wdata, a_addr, a_rdata;
   logic       a_tx_valid, a_en, a_we, a_busy, a_err_ovr, a_err_seq;
   logic [7:0] b_tx_data, b_wdata, b_addr, b_rdata;
   logic       b_tx_valid, b_en, b_we, b_busy, b_err_ovr, b_err_seq;
   logic [7:0] c_tx_data, c_wdata, c_rdata;
   logic [3:0] c_addr;
   logic       c_tx_valid, c_en, c_we, c_busy, c_err_ovr, c_err_seq;

   spi_ram_ctrl #(.ADDR_W(8), .RD_LAT(2), .AUTO_INC(0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid[0]),
      .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ack(tx_ack[0]),
      .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
      .mem_rdata(a_rdata), .busy(a_busy), .err_ovr(a_err_ovr), .err_seq(a_err_seq));

   spi_ram_ctrl #(.ADDR_W(8), .RD_LAT(1), .AUTO_INC(1)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid[1]),
      .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ack(tx_ack[1]),
      .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
      .mem_rdata(b_rdata), .busy(b_busy), .err_ovr(b_err_ovr), .err_seq(b_err_seq));

   spi_ram_ctrl #(.ADDR_W(4), .RD_LAT(4), .AUTO_INC(1)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid[2]),
      .tx_data(c_tx_data), .tx_valid(c_tx_valid), .tx_ack(tx_ack[2]),
      .mem_en(c_en), .mem_we(c_we), .mem_addr(c_addr), .mem_wdata(c_wdata),
      .mem_rdata(c_rdata), .busy(c_busy), .err_ovr(c_err_ovr), .err_seq(c_err_seq));

   // RAM models: read data is only correct on the exact cycle RD_LAT after the strobe
   logic [7:0] ram_a [256];
   logic [7:0] ram_b [256];
   logic [7:0] ram_c [16];
   logic [7:0] pipe_a [4];
   logic [7:0] pipe_b [4];
   logic [7:0] pipe_c [4];

   always @(posedge clk) begin
      if (a_en && a_we) ram_a[a_addr] <= a_wdata;
      if (b_en && b_we) ram_b[b_addr] <= b_wdata;
      if (c_en && c_we) ram_c[c_addr] <= c_wdata;
      pipe_a[0] <= (a_en && !a_we) ? ram_a[a_addr] : 8'hEE;
      pipe_b[0] <= (b_en && !b_we) ? ram_b[b_addr] : 8'hEE;
      pipe_c[0] <= (c_en && !c_we) ? ram_c[c_addr] : 8'hEE;
      for (int i = 1; i < 4; i++) begin
         pipe_a[i] <= pipe_a[i-1];
         pipe_b[i] <= pipe_b[i-1];
         pipe_c[i] <= pipe_c[i-1];
      end
   end

   assign a_rdata = pipe_a[1];
   assign b_rdata = pipe_b[0];
   assign c_rdata = pipe_c[3];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Command presented for one cycle; returns at the sample point of the cycle after acceptance
   task automatic send(input int which, input logic [1:0] cmd, input logic [7:0] payload);
      @(negedge clk);
      rx_data         = {cmd, payload};
      rx_valid[which] = 1'b1;
      @(negedge clk);
      rx_valid[which] = 1'b0;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (a_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b expected 0", a_tx_valid); end
      n_checks++; if (a_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en: got %b expected 0", a_en); end
      n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", a_busy); end
      n_checks++; if (a_addr !== 8'h00) begin n_fail++; $display("FAIL rst_mem_addr: got %h expected 00", a_addr); end
      n_checks++; if (a_tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h expected 00", a_tx_data); end
      n_checks++; if ({a_err_ovr, a_err_seq, a_we} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b expected 000", {a_err_ovr, a_err_seq, a_we}); end
      repeat (2) @(negedge clk);
      n_checks++; if (a_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_mem_wdata: got %h expected 00", a_wdata); end
      rst_n = 1'b1;
   endtask

   task automatic test_err_seq;
      send(0, CMD_RD_DATA, 8'h00);
      n_checks++; if (a_err_seq !== 1'b1) begin n_fail++; $display("FAIL seq_pulse: got %b expected 1", a_err_seq); end
      n_checks++; if (a_en !== 1'b0) begin n_fail++; $display("FAIL seq_mem_en: got %b expected 0", a_en); end
      n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL seq_busy: got %b expected 0", a_busy); end
      @(negedge clk);
      n_checks++; if (a_err_seq !== 1'b0) begin n_fail++; $display("FAIL seq_pulse_end: got %b expected 0", a_err_seq); end
      n_checks++; if (a_tx_valid !== 1'b0) begin n_fail++; $display("FAIL seq_tx_valid: got %b expected 0", a_tx_valid); end
   endtask

   task automatic test_write;
      send(0, CMD_WR_ADDR, 8'h3C);
      n_checks++; if (a_en !== 1'b0) begin n_fail++; $display("FAIL wa_no_access: got %b expected 0", a_en); end
      send(0, CMD_WR_DATA, 8'hA5);
      n_checks++; if ({a_en, a_we} !== 2'b11) begin n_fail++; $display("FAIL wr_strobe: got %b expected 11", {a_en, a_we}); end
      n_checks++; if (a_addr !== 8'h3C) begin n_fail++; $display("FAIL wr_addr: got %h expected 3c", a_addr); end
      n_checks++; if (a_wdata !== 8'hA5) begin n_fail++; $display("FAIL wr_wdata: got %h expected a5", a_wdata); end
      n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b expected 1", a_busy); end
      @(negedge clk);
      n_checks++; if ({a_en, a_busy} !== 2'b00) begin n_fail++; $display("FAIL wr_done: got en,busy=%b expected 00", {a_en, a_busy}); end
      n_checks++; if (a_addr !== 8'h3C) begin n_fail++; $display("FAIL wr_addr_hold: got %h expected 3c", a_addr); end
   endtask

   task automatic test_read;
      send(0, CMD_RD_ADDR, 8'h3C);
      n_checks++; if (a_en !== 1'b0) begin n_fail++; $display("FAIL ra_no_access: got %b expected 0", a_en); end
      send(0, CMD_RD_DATA, 8'h00);
      n_checks++; if ({a_en, a_we} !== 2'b10) begin n_fail++; $display("FAIL rd_strobe: got %b expected 10", {a_en, a_we}); end
      n_checks++; if (a_addr !== 8'h3C) begin n_fail++; $display("FAIL rd_addr: got %h expected 3c", a_addr); end
      @(negedge clk);
      n_checks++; if ({a_en, a_busy, a_tx_valid} !== 3'b010) begin n_fail++; $display("FAIL rd_c2: got en,busy,txv=%b expected 010", {a_en, a_busy, a_tx_valid}); end
      @(negedge clk);
      n_checks++; if ({a_busy, a_tx_valid} !== 2'b10) begin n_fail++; $display("FAIL rd_c3: got busy,txv=%b expected 10", {a_busy, a_tx_valid}); end
      @(negedge clk);
      n_checks++; if ({a_busy, a_tx_valid} !== 2'b01) begin n_fail++; $display("FAIL rd_c4: got busy,txv=%b expected 01", {a_busy, a_tx_valid}); end
      n_checks++; if (a_tx_data !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h expected a5", a_tx_data); end
      @(negedge clk);
      n_checks++; if (a_tx_valid !== 1'b1) begin n_fail++; $display("FAIL rd_hold: got %b expected 1", a_tx_valid); end
      @(negedge clk);
      tx_ack[0] = 1'b1;
      @(negedge clk);
      tx_ack[0] = 1'b0;
      n_checks++; if (a_tx_valid !== 1'b0) begin n_fail++; $display("FAIL rd_ack: got %b expected 0", a_tx_valid); end
      n_checks++; if (a_tx_data !== 8'hA5) begin n_fail++; $display("FAIL rd_data_stable: got %h expected a5", a_tx_data); end
   endtask

   task automatic test_overrun;
      send(0, CMD_RD_DATA, 8'h00);
      send(0, CMD_WR_DATA, 8'h77);
      n_checks++; if (a_err_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse: got %b expected 1", a_err_ovr); end
      n_checks++; if ({a_en, a_busy} !== 2'b01) begin n_fail++; $display("FAIL ovr_inflight: got en,busy=%b expected 01", {a_en, a_busy}); end
      @(negedge clk);
      n_checks++; if (a_err_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_pulse_end: got %b expected 0", a_err_ovr); end
      n_checks++; if ({a_tx_valid, a_tx_data} !== 9'h1A5) begin n_fail++; $display("FAIL ovr_read: got txv,data=%h expected 1a5", {a_tx_valid, a_tx_data}); end
      n_checks++; if (a_wdata !== 8'hA5) begin n_fail++; $display("FAIL ovr_dropped: got wdata %h expected a5", a_wdata); end
      @(negedge clk);
      rx_data     = {CMD_WR_ADDR, 8'h05};
      rx_valid[0] = 1'b1;
      tx_ack[0]   = 1'b1;
      @(negedge clk);
      rx_valid[0] = 1'b0;
      tx_ack[0]   = 1'b0;
      n_checks++; if (a_tx_valid !== 1'b0) begin n_fail++; $display("FAIL ack_cmd_txv: got %b expected 0", a_tx_valid); end
      send(0, CMD_WR_DATA, 8'h5A);
      n_checks++; if ({a_en, a_addr, a_wdata} !== 17'h1055A) begin n_fail++; $display("FAIL ack_cmd_wr: got en,addr,wdata=%h expected 1055a", {a_en, a_addr, a_wdata}); end
   endtask

   task automatic test_auto_inc;
      send(1, CMD_WR_ADDR, 8'hFF);
      send(1, CMD_WR_DATA, 8'h11);
      n_checks++; if ({b_en, b_we, b_addr, b_wdata} !== 18'h3FF11) begin n_fail++; $display("FAIL ai_wr0: got %h expected 3ff11", {b_en, b_we, b_addr, b_wdata}); end
      send(1, CMD_WR_DATA, 8'h22);
      n_checks++; if ({b_en, b_we, b_addr, b_wdata} !== 18'h30022) begin n_fail++; $display("FAIL ai_wr_wrap: got %h expected 30022", {b_en, b_we, b_addr, b_wdata}); end
      send(1, CMD_RD_ADDR, 8'hFF);
      send(1, CMD_RD_DATA, 8'h00);
      n_checks++; if ({b_en, b_we, b_addr} !== 10'h2FF) begin n_fail++; $display("FAIL ai_rd0: got %h expected 2ff", {b_en, b_we, b_addr}); end
      repeat (2) @(negedge clk);
      n_checks++; if ({b_tx_valid, b_tx_data} !== 9'h111) begin n_fail++; $display("FAIL ai_rd0_data: got %h expected 111", {b_tx_valid, b_tx_data}); end
      send(1, CMD_RD_DATA, 8'h00);
      n_checks++; if ({b_en, b_addr, b_tx_valid} !== 10'h200) begin n_fail++; $display("FAIL ai_rd_wrap: got en,addr,txv=%h expected 200", {b_en, b_addr, b_tx_valid}); end
      repeat (2) @(negedge clk);
      n_checks++; if ({b_tx_valid, b_tx_data} !== 9'h122) begin n_fail++; $display("FAIL ai_rd1_data: got %h expected 122", {b_tx_valid, b_tx_data}); end
      n_checks++; if ({b_busy, b_err_ovr, b_err_seq} !== 3'b000) begin n_fail++; $display("FAIL ai_flags: got %b expected 000", {b_busy, b_err_ovr, b_err_seq}); end
   endtask

   task automatic test_narrow;
      send(2, CMD_WR_ADDR, 8'hFF);
      send(2, CMD_WR_DATA, 8'h3C);
      n_checks++; if ({c_en, c_we, c_addr, c_wdata} !== 14'h3F3C) begin n_fail++; $display("FAIL nw_wr: got %h expected 3f3c", {c_en, c_we, c_addr, c_wdata}); end
      send(2, CMD_WR_DATA, 8'h4D);
      n_checks++; if ({c_en, c_addr} !== 5'h10) begin n_fail++; $display("FAIL nw_wrap: got en,addr=%h expected 10", {c_en, c_addr}); end
      send(2, CMD_RD_ADDR, 8'hF0);
      send(2, CMD_RD_DATA, 8'h00);
      n_checks++; if ({c_en, c_we, c_addr} !== 6'h20) begin n_fail++; $display("FAIL nw_rd: got %h expected 20", {c_en, c_we, c_addr}); end
      repeat (4) @(negedge clk);
      n_checks++; if ({c_busy, c_tx_valid} !== 2'b10) begin n_fail++; $display("FAIL nw_c5: got busy,txv=%b expected 10", {c_busy, c_tx_valid}); end
      @(negedge clk);
      n_checks++; if ({c_busy, c_tx_valid, c_tx_data} !== 10'h14D) begin n_fail++; $display("FAIL nw_c6: got %h expected 14d", {c_busy, c_tx_valid, c_tx_data}); end
      n_checks++; if ({c_err_ovr, c_err_seq} !== 2'b00) begin n_fail++; $display("FAIL nw_flags: got %b expected 00", {c_err_ovr, c_err_seq}); end
   endtask

   task automatic test_reset_mid_read;
      send(0, CMD_RD_DATA, 8'h00);
      @(negedge clk);
      n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL mr_pre_busy: got %b expected 1", a_busy); end
      #1 rst_n = 1'b0;
      #1;
      n_checks++; if ({a_en, a_busy, a_tx_valid} !== 3'b000) begin n_fail++; $display("FAIL mr_async: got en,busy,txv=%b expected 000", {a_en, a_busy, a_tx_valid}); end
      n_checks++; if (a_addr !== 8'h00) begin n_fail++; $display("FAIL mr_addr: got %h expected 00", a_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      send(0, CMD_RD_DATA, 8'h00);
      n_checks++; if ({a_err_seq, a_en} !== 2'b10) begin n_fail++; $display("FAIL mr_seq: got err_seq,en=%b expected 10", {a_err_seq, a_en}); end
      repeat (3) @(negedge clk);
      n_checks++; if (a_tx_valid !== 1'b0) begin n_fail++; $display("FAIL mr_no_tx: got %b expected 0", a_tx_valid); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b1;
      rx_data  = '0;
      rx_valid = '0;
      tx_ack   = '0;
      test_reset;
      test_err_seq;
      test_write;
      test_read;
      test_overrun;
      test_auto_inc;
      test_narrow;
      test_reset_mid_read;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
